muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit beside the single-cycle integer ALU in the core's execute stage. Accepts two 32-bit operands and an M-extension funct3 code, runs a radix-2 shift-add multiply or restoring divide over 32 iterations, and returns one 32-bit result with a single-cycle completion pulse. Execute stalls on `busy` and captures `O` on `done`.

---
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional zero-operand shortcut when MULDIV_EARLY_OUT_EN is defined.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        kill,
  input  logic [2:0]  funct3,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] O,
  output logic        Z
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [4:0]  cnt;
  logic [63:0] prod;
  logic [31:0] m;
  logic [2:0]  op;
  logic        negq;
  logic        negr;

  logic        sa;
  logic        sb;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        divop;
  logic        bz;
  logic        early;

  logic [32:0] msum;
  logic [63:0] mstep;
  logic [32:0] rsh;
  logic [32:0] diff;
  logic [63:0] dstep;

  logic [63:0] pfix;
  logic [31:0] qfix;
  logic [31:0] rfix;
  logic [31:0] res;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (funct3)
      3'b001, 3'b100, 3'b110: begin
        sa = 1'b1;
        sb = 1'b1;
      end
      3'b010: sa = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = sa & A[31];
  assign b_neg = sb & B[31];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;
  assign divop = funct3[2];
  assign bz    = (B == 32'd0);

`ifdef MULDIV_EARLY_OUT_EN
  logic [31:0] early_res;

  assign early = start & (bz | (~divop & (A == 32'd0)));

  always_comb begin
    early_res = 32'd0;
    if (divop)
      early_res = funct3[1] ? A : 32'hFFFF_FFFF;
  end
`else
  assign early = 1'b0;
`endif

  // multiply: low half holds the multiplier, adds land in the high half
  assign msum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, m} : 33'd0);
  assign mstep = {msum, prod[31:1]};

  // divide: high half is the partial remainder, low half the quotient
  assign rsh   = {prod[63:32], prod[31]};
  assign diff  = rsh - {1'b0, m};
  assign dstep = diff[32] ? {rsh[31:0], prod[30:0], 1'b0}
                          : {diff[31:0], prod[30:0], 1'b1};

  assign pfix = negq ? -prod : prod;
  assign qfix = negq ? -prod[31:0] : prod[31:0];
  assign rfix = negr ? -prod[63:32] : prod[63:32];

  always_comb begin
    res = 32'd0;
    unique case (op)
      3'b000:                 res = pfix[31:0];
      3'b001, 3'b010, 3'b011: res = pfix[63:32];
      3'b100, 3'b101:         res = qfix;
      default:                res = rfix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = early ? DONE : RUN;
      RUN:   if (cnt == 5'd31) state_nx = FIXUP;
      FIXUP: state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (kill)
      state_nx = IDLE;
  end

  assign busy = (state == RUN) | (state == FIXUP);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 5'd0;
      prod <= 64'd0;
      m    <= 32'd0;
      op   <= 3'd0;
      negq <= 1'b0;
      negr <= 1'b0;
      O    <= 32'd0;
      Z    <= 1'b1;
    end else if (!kill) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op   <= funct3;
            cnt  <= 5'd0;
            m    <= divop ? b_mag : a_mag;
            prod <= {32'd0, divop ? a_mag : b_mag};
            // a zero divisor must leave the all-ones quotient unsigned
            negq <= (a_neg ^ b_neg) & ~(divop & bz);
            negr <= a_neg;
`ifdef MULDIV_EARLY_OUT_EN
            if (early) begin
              O <= early_res;
              Z <= (early_res == 32'd0);
            end
`endif
          end
        end
        RUN: begin
          prod <= op[2] ? dstep : mstep;
          cnt  <= cnt + 5'd1;
        end
        FIXUP: begin
          O <= res;
          Z <= (res == 32'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, start-ignore,
// kill, and mid-run reset scenarios.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] O;
  logic        Z;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] o;
    int          st;
    int          lat;
  } exp_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  exp_t sb[$];
  vec_t vs[$];
  exp_t ex;

  muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .O      (O),
    .Z      (Z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic bit early(input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    return (b == 32'd0) || (!f[2] && a == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done actual=done O=%h required=no done", O);
      end else begin
        ex = sb.pop_front();
        chk("result_O", O, ex.o);
        chk("result_Z", {31'd0, Z}, {31'd0, ex.o == 32'd0});
        chk("latency", cyc - ex.st, ex.lat);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input bit push,
                       input logic [31:0] e);
    bit   eo;
    exp_t x;
    @(negedge clk);
    funct3 = f;
    A      = a;
    B      = b;
    start  = 1'b1;
    eo     = early(f, a, b);
    if (push) begin
      x.o   = e;
      x.st  = cyc + 1;
      x.lat = eo ? 0 : 33;
      sb.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, eo ? 32'd0 : 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++)
      @(negedge clk);
    @(negedge clk);
    chk("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic add(input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] e);
    vec_t v;
    v.f = f;
    v.a = a;
    v.b = b;
    v.e = e;
    vs.push_back(v);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    kill   = 1'b0;
    funct3 = 3'd0;
    A      = 32'd0;
    B      = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_O", O, 32'd0);
    chk("reset_Z", {31'd0, Z}, 32'd1);
    rst = 1'b0;

    add(3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    add(3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    add(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    add(3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    add(3'b001, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
    add(3'b001, 32'd7,          32'd3,         32'd0);
    add(3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    add(3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    add(3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD);
    add(3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1);
    add(3'b101, 32'd100,        32'd7,         32'd14);
    add(3'b111, 32'd100,        32'd7,         32'd2);
    add(3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF);
    add(3'b110, 32'd5,          32'd0,         32'd5);
    add(3'b100, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF);
    add(3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9);
    add(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    add(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
    add(3'b000, 32'd0,          32'd12345,     32'd0);

    foreach (vs[i]) begin
      issue(vs[i].f, vs[i].a, vs[i].b, 1'b1, vs[i].e);
      drain();
    end

    issue(3'b000, 32'd3, 32'd5, 1'b1, 32'd15);
    repeat (9) @(negedge clk);
    start  = 1'b1;
    funct3 = 3'b011;
    A      = 32'hFFFF_FFFF;
    B      = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    issue(3'b101, 32'd100, 32'd7, 1'b0, 32'd0);
    repeat (19) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", {31'd0, busy}, 32'd0);
    chk("kill_done", {31'd0, done}, 32'd0);
    chk("kill_O_kept", O, 32'd15);
    repeat (40) @(negedge clk);
    chk("kill_O_after", O, 32'd15);
    chk("kill_Z_after", {31'd0, Z}, 32'd0);

    @(negedge clk);
    funct3 = 3'b000;
    A      = 32'd2;
    B      = 32'd3;
    start  = 1'b1;
    kill   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    kill  = 1'b0;
    chk("kill_start_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("kill_start_O", O, 32'd15);

    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_O", O, 32'd0);
    chk("rst_Z", {31'd0, Z}, 32'd1);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE);
    drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
